// File: rtl/isr_pkg.sv
// Shared definitions for the parametrised integer square root engine.
//   isr_state_t      : control states of the engine (IDLE, CALC, DONE)
//   isr_cnt_width    : width of the iteration counter for a given ITER
//   isr_params_legal : elaboration-time legality of WIDTH / BITS_PER_CYCLE
package isr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isr_state_t;

    // Counter must be able to hold ITER itself, not just ITER-1.
    function automatic int isr_cnt_width(input int iter);
        return $clog2(iter + 32'sd1);
    endfunction

    // WIDTH must be even and at least 4 so the root is at least 2 bits wide,
    // and the steps per cycle must tile the root exactly.
    function automatic bit isr_params_legal(input int width, input int bpc);
        if ((width < 32'sd4) || ((width % 32'sd2) != 32'sd0) || (bpc < 32'sd1)) begin
            return 1'b0;
        end else begin
            return ((width / 32'sd2) % bpc) == 32'sd0;
        end
    endfunction

endpackage

// File: rtl/isr_step.sv
// One digit-by-digit square root step (purely combinational).
// Ports:
//   root      in  RW    partial root so far
//   rem       in  RW+2  partial remainder so far
//   pair      in  2     next two radicand bits, MSB first
//   root_next out RW    partial root with one more bit resolved
//   rem_next  out RW+2  updated partial remainder
module isr_step #(
    parameter int RW = 32
) (
    input  logic [RW-1:0] root,
    input  logic [RW+1:0] rem,
    input  logic [1:0]    pair,
    output logic [RW-1:0] root_next,
    output logic [RW+1:0] rem_next
);

    logic [RW+1:0] shifted_s;
    logic [RW+1:0] trial_s;
    logic          unused_rem_top_s;

    // Before any step the partial root has fewer than RW bits, so the incoming
    // remainder (<= 2*root) always fits in its low RW bits; the top two bits
    // only become non-zero after the final step and never feed another step.
    assign unused_rem_top_s = ^rem[RW+1:RW];

    // Trial subtraction of (root<<2)|1 from (rem<<2)|pair
    always_comb begin
        shifted_s = {rem[RW-1:0], pair};
        trial_s   = {root, 2'b01};
        if (shifted_s >= trial_s) begin
            rem_next  = shifted_s - trial_s;
            root_next = {root[RW-2:0], 1'b1};
        end else begin
            rem_next  = shifted_s;
            root_next = {root[RW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/isr_pipe_param.sv
// Parametrised integer square root unit with valid/ready on both sides.
// Computes floor(sqrt(value)) and value - result^2 by shift-subtract,
// resolving BITS_PER_CYCLE root bits per CALC cycle (ITER cycles total).
// Ports:
//   clock      in  1        system clock
//   reset_n    in  1        synchronous active-low reset
//   in_valid   in  1        request present on value
//   in_ready   out 1        request accepted this cycle when in_valid
//   value      in  WIDTH    radicand, captured at the input handshake
//   out_valid  out 1        result/remainder valid
//   out_ready  in  1        consumer takes the result this cycle
//   result     out WIDTH/2  floor(sqrt(value))
//   remainder  out WIDTH/2+1 value - result*result
module isr_pipe_param
    import isr_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] result,
    output logic [WIDTH/2:0]   remainder
);

    localparam int RW    = WIDTH / 2;
    localparam int ITER  = RW / BITS_PER_CYCLE;
    localparam int CNT_W = isr_cnt_width(ITER);
    localparam int SHIFT = 2 * BITS_PER_CYCLE;

    if (!isr_params_legal(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
        $error("isr_pipe_param: WIDTH must be even and >= 4, BITS_PER_CYCLE must divide WIDTH/2");
    end

    isr_state_t       state_r;
    isr_state_t       state_nxt_s;
    logic [WIDTH-1:0] op_r;
    logic [RW-1:0]    root_r;
    logic [RW+1:0]    rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic [RW-1:0]    root_calc_s;
    logic [RW+1:0]    rem_calc_s;

    // Chain of steps; stage j consumes operand bits just below stage j-1's.
    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
        logic [RW-1:0] root_prev_s;
        logic [RW+1:0] rem_prev_s;
        logic [RW-1:0] root_step_s;
        logic [RW+1:0] rem_step_s;

        if (j == 0) begin : g_first
            assign root_prev_s = root_r;
            assign rem_prev_s  = rem_r;
        end else begin : g_chain
            assign root_prev_s = g_step[j-1].root_step_s;
            assign rem_prev_s  = g_step[j-1].rem_step_s;
        end

        isr_step #(.RW(RW)) u_step (
            .root      (root_prev_s),
            .rem       (rem_prev_s),
            .pair      (op_r[WIDTH-1-2*j -: 2]),
            .root_next (root_step_s),
            .rem_next  (rem_step_s)
        );
    end

    assign root_calc_s = g_step[BITS_PER_CYCLE-1].root_step_s;
    assign rem_calc_s  = g_step[BITS_PER_CYCLE-1].rem_step_s;

    // In DONE a waiting request may be taken on the same edge the result leaves.
    assign in_ready  = reset_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == DONE);
    assign result    = root_r;
    assign remainder = rem_r[RW:0];

    // Control state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (!out_ready) begin
                    state_nxt_s = DONE;
                end else if (accept_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand shifter, partial root/remainder and iteration counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_r   <= '0;
            root_r <= '0;
            rem_r  <= '0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        op_r   <= value;
                        root_r <= '0;
                        rem_r  <= '0;
                        cnt_r  <= CNT_W'(ITER);
                    end else begin
                        op_r   <= op_r;
                        root_r <= root_r;
                        rem_r  <= rem_r;
                        cnt_r  <= cnt_r;
                    end
                end
                CALC: begin
                    op_r   <= op_r << SHIFT;
                    root_r <= root_calc_s;
                    rem_r  <= rem_calc_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                end
                default: begin
                    op_r   <= op_r;
                    root_r <= root_r;
                    rem_r  <= rem_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

endmodule
